// File: rtl/pipe_stage_skid.sv
// Single pipeline stage with a one-entry skid register. in_ready depends only on
// registered state, so there is no combinational path from out_ready back upstream.
//
//   state | meaning
//   EMPTY | no word held, out_valid=0
//   ONE   | main register holds the output word
//   FULL  | main holds the output word, skid holds the next one; upstream stalled
module pipe_stage_skid #(
   parameter int DATA_W = 32,
   parameter int SIDE_W = 64,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [SIDE_W-1:0] in_side,
   input  logic              kill,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [SIDE_W-1:0] out_side,
   output logic              out_bubble,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   main_data_q, main_data_d, skid_data_q, skid_data_d;
   logic [SIDE_W-1:0]   main_side_q, main_side_d, skid_side_q, skid_side_d;
   logic                main_bubble_q, main_bubble_d, skid_bubble_q, skid_bubble_d;
   logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

   logic                in_fire, out_fire;
   logic [DATA_W-1:0]   word_data;

   assign in_ready   = (state_q != FULL) && !rst;
   assign out_valid  = (state_q != EMPTY) && !rst;
   assign out_data   = main_data_q;
   assign out_side   = main_side_q;
   assign out_bubble = main_bubble_q;
   assign stall_cnt  = stall_cnt_q;

   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;
   // A killed word keeps its sideband (pc) but loses its payload.
   assign word_data = kill ? '0 : in_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= EMPTY;
         main_data_q   <= '0;
         main_side_q   <= '0;
         main_bubble_q <= 1'b0;
         skid_data_q   <= '0;
         skid_side_q   <= '0;
         skid_bubble_q <= 1'b0;
         stall_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         main_data_q   <= main_data_d;
         main_side_q   <= main_side_d;
         main_bubble_q <= main_bubble_d;
         skid_data_q   <= skid_data_d;
         skid_side_q   <= skid_side_d;
         skid_bubble_q <= skid_bubble_d;
         stall_cnt_q   <= stall_cnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      main_data_d   = main_data_q;
      main_side_d   = main_side_q;
      main_bubble_d = main_bubble_q;
      skid_data_d   = skid_data_q;
      skid_side_d   = skid_side_q;
      skid_bubble_d = skid_bubble_q;
      stall_cnt_d   = stall_cnt_q;

      if (out_valid && !out_ready && (stall_cnt_q != CNT_MAX))
         stall_cnt_d = stall_cnt_q + 1'b1;

      if (flush) begin
         state_d       = EMPTY;
         main_data_d   = '0;
         main_side_d   = '0;
         main_bubble_d = 1'b0;
         skid_data_d   = '0;
         skid_side_d   = '0;
         skid_bubble_d = 1'b0;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  state_d       = ONE;
                  main_data_d   = word_data;
                  main_side_d   = in_side;
                  main_bubble_d = kill;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_data_d   = word_data;
                  main_side_d   = in_side;
                  main_bubble_d = kill;
               end else if (in_fire) begin
                  state_d       = FULL;
                  skid_data_d   = word_data;
                  skid_side_d   = in_side;
                  skid_bubble_d = kill;
               end else if (out_fire) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (out_fire) begin
                  state_d       = ONE;
                  main_data_d   = skid_data_q;
                  main_side_d   = skid_side_q;
                  main_bubble_d = skid_bubble_q;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus random traffic, all checked
// against a two-entry FIFO model of the stage.
module tb_pipe_stage_skid;

   localparam int DW = 32;
   localparam int SW = 64;
   localparam int CW = 4;
   localparam int VW = 2 + DW + SW + 1 + CW;
   localparam int CMAX = (1 << CW) - 1;

   typedef struct {
      logic [DW-1:0] d;
      logic [SW-1:0] s;
      logic          b;
   } word_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic [SW-1:0] in_side = '0;
   logic          kill = 1'b0;
   logic          flush = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic [SW-1:0] out_side;
   logic          out_bubble;
   logic [CW-1:0] stall_cnt;

   int n_vec = 0;
   int n_bad = 0;

   word_t mq[$];
   int    m_cnt = 0;
   bit    m_zero = 1'b0;
   logic [VW-1:0] obs;

   pipe_stage_skid #(.DATA_W(DW), .SIDE_W(SW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_side(in_side),
      .kill(kill), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_side(out_side), .out_bubble(out_bubble), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   always_comb obs = {in_ready, out_valid, out_data, out_side, out_bubble, stall_cnt};

   task automatic drive(input bit v, input logic [DW-1:0] d, input logic [SW-1:0] s,
                        input bit k, input bit f, input bit r);
      in_valid  = v;
      in_data   = d;
      in_side   = s;
      kill      = k;
      flush     = f;
      out_ready = r;
   endtask

   // Advance the model by one clock using the inputs currently applied, then let
   // the DUT take the same edge.
   task automatic tick();
      word_t w;
      bit ov, ofire, ifire;
      if (rst) begin
         mq.delete();
         m_cnt  = 0;
         m_zero = 1'b1;
      end else begin
         ov    = mq.size() > 0;
         ofire = ov && out_ready;
         ifire = in_valid && (mq.size() < 2);
         if (ov && !out_ready && m_cnt < CMAX) m_cnt++;
         if (flush) begin
            mq.delete();
            m_zero = 1'b1;
         end else begin
            if (ofire) void'(mq.pop_front());
            if (ifire) begin
               w.d = kill ? '0 : in_data;
               w.s = in_side;
               w.b = kill;
               mq.push_back(w);
               m_zero = 1'b0;
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [VW-1:0] exp_vec();
      logic [DW-1:0] d;
      logic [SW-1:0] s;
      logic          b;
      logic [CW-1:0] c;
      d = '0; s = '0; b = 1'b0;
      if (mq.size() > 0) begin
         d = mq[0].d; s = mq[0].s; b = mq[0].b;
      end
      c = m_cnt[CW-1:0];
      return {!rst && (mq.size() < 2), !rst && (mq.size() > 0), d, s, b, c};
   endfunction

   // Payload fields are only defined while a word is held or right after a clear.
   function automatic logic [VW-1:0] exp_mask();
      logic [DW+SW:0] fm;
      fm = (mq.size() > 0 || m_zero) ? '1 : '0;
      return {2'b11, fm, {CW{1'b1}}};
   endfunction

   task automatic test_reset();
      drive(0, '0, '0, 0, 0, 0);
      rst = 1'b1;
      tick();
      n_vec++;
      if (obs !== '0) begin
         n_bad++;
         $display("FAIL reset_state: got %h want 0", obs);
      end
      tick();
      n_vec++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_held: got ready=%b valid=%b want 0 0", in_ready, out_valid);
      end
      rst = 1'b0;
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_release_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_stream();
      for (int i = 1; i <= 3; i++) begin
         drive(1, DW'(i), SW'(i * 16), 0, 0, 1);
         tick();
         n_vec++;
         if (out_valid !== 1'b1 || out_data !== DW'(i) || stall_cnt !== '0) begin
            n_bad++;
            $display("FAIL stream_word%0d: got v=%b d=%h c=%0d want v=1 d=%h c=0",
                     i, out_valid, out_data, stall_cnt, DW'(i));
         end
      end
      drive(0, '0, '0, 0, 0, 1);
      tick();
      n_vec++;
      if (((obs ^ exp_vec()) & exp_mask()) !== '0) begin
         n_bad++;
         $display("FAIL stream_drain: got %h want %h", obs, exp_vec());
      end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] a, b;
      a = 32'hAAAA_0001;
      b = 32'hBBBB_0002;
      drive(1, a, 64'hA, 0, 0, 0);
      tick();
      drive(1, b, 64'hB, 0, 0, 0);
      tick();
      n_vec++;
      if (in_ready !== 1'b0 || out_data !== a) begin
         n_bad++;
         $display("FAIL bp_full: got ready=%b d=%h want ready=0 d=%h", in_ready, out_data, a);
      end
      drive(0, '0, '0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++;
         if (((obs ^ exp_vec()) & exp_mask()) !== '0) begin
            n_bad++;
            $display("FAIL bp_hold%0d: got %h want %h", i, obs, exp_vec());
         end
      end
      drive(0, '0, '0, 0, 0, 1);
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== b) begin
         n_bad++;
         $display("FAIL bp_second: got v=%b d=%h want v=1 d=%h", out_valid, out_data, b);
      end
      tick();
      n_vec++;
      if (((obs ^ exp_vec()) & exp_mask()) !== '0) begin
         n_bad++;
         $display("FAIL bp_empty: got %h want %h", obs, exp_vec());
      end
   endtask

   task automatic test_kill();
      drive(1, 32'h8C01_0004, 64'h0000000C_00000008, 1, 0, 0);
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== '0 || out_side !== 64'h0000000C_00000008
          || out_bubble !== 1'b1) begin
         n_bad++;
         $display("FAIL kill_word: got v=%b d=%h s=%h b=%b want 1 0 0000000c00000008 1",
                  out_valid, out_data, out_side, out_bubble);
      end
      drive(0, 32'h1234_5678, 64'h55, 1, 0, 0);
      tick();
      n_vec++;
      if (((obs ^ exp_vec()) & exp_mask()) !== '0) begin
         n_bad++;
         $display("FAIL kill_no_fire: got %h want %h", obs, exp_vec());
      end
      drive(1, 32'h1111_2222, 64'h77, 0, 0, 1);
      tick();
      n_vec++;
      if (out_data !== 32'h1111_2222 || out_bubble !== 1'b0) begin
         n_bad++;
         $display("FAIL kill_clean_next: got d=%h b=%b want 11112222 0", out_data, out_bubble);
      end
      drive(0, '0, '0, 0, 0, 1);
      tick();
   endtask

   task automatic test_flush_full();
      drive(1, 32'hF00D_0001, 64'h1, 0, 0, 0);
      tick();
      drive(1, 32'hF00D_0002, 64'h2, 0, 0, 0);
      tick();
      drive(1, 32'hDEAD_BEEF, 64'hDEAD, 0, 1, 0);
      tick();
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
         n_bad++;
         $display("FAIL flush_full: got v=%b r=%b d=%h want 0 1 0", out_valid, in_ready, out_data);
      end
      drive(0, '0, '0, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++;
         if (out_valid !== 1'b0 || ((obs ^ exp_vec()) & exp_mask()) !== '0) begin
            n_bad++;
            $display("FAIL flush_after%0d: got %h want %h", i, obs, exp_vec());
         end
      end
   endtask

   task automatic test_saturation();
      drive(1, 32'h5A5A_5A5A, 64'h9, 0, 0, 0);
      tick();
      drive(0, '0, '0, 0, 0, 0);
      for (int i = 0; i < 20; i++) tick();
      n_vec++;
      if (stall_cnt !== CW'(CMAX)) begin
         n_bad++;
         $display("FAIL sat_value: got %0d want %0d", stall_cnt, CMAX);
      end
      drive(0, '0, '0, 0, 1, 0);
      tick();
      n_vec++;
      if (stall_cnt !== CW'(CMAX) || out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL sat_flush_keep: got c=%0d v=%b want %0d 0", stall_cnt, out_valid, CMAX);
      end
   endtask

   task automatic test_reset_full();
      drive(1, 32'hC0DE_0001, 64'h11, 0, 0, 0);
      tick();
      drive(1, 32'hC0DE_0002, 64'h22, 0, 0, 0);
      tick();
      drive(1, 32'hC0DE_0003, 64'h33, 1, 1, 1);
      rst = 1'b1;
      tick();
      n_vec++;
      if (obs !== '0) begin
         n_bad++;
         $display("FAIL rst_full_clear: got %h want 0", obs);
      end
      tick();
      n_vec++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_full_held: got r=%b v=%b want 0 0", in_ready, out_valid);
      end
      drive(0, '0, '0, 0, 0, 1);
      rst = 1'b0;
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_full_release: got %b want 1", in_ready);
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 99) < 2);
         drive($urandom_range(0, 9) < 7, DW'($urandom), {32'($urandom), 32'($urandom)},
               $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
               $urandom_range(0, 9) < 6);
         tick();
         n_vec++;
         if (((obs ^ exp_vec()) & exp_mask()) !== '0) begin
            n_bad++;
            $display("FAIL random_cycle%0d: got %h want %h mask %h", i, obs, exp_vec(), exp_mask());
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_stream();
      test_backpressure();
      test_kill();
      test_flush_full();
      test_saturation();
      test_reset_full();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter DATA_W, default 32: payload width (instruction word); zeroed on kill.
REQ-002 Parameter SIDE_W, default 64: sideband width (e.g. {pc8,pc4}); preserved on kill.
REQ-003 Parameter CNT_W, default 16: stall counter width.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  upstream word present.
REQ-007 in_ready  out  1  stage can accept a word this cycle.
REQ-008 in_data  in  DATA_W  upstream payload.
REQ-009 in_side  in  SIDE_W  upstream sideband.
REQ-010 kill  in  1  convert the word accepted this cycle into a bubble.
REQ-011 flush  in  1  discard all held words and any word offered this cycle.
REQ-012 out_valid  out  1  downstream word present.
REQ-013 out_ready  in  1  downstream accepts out word this cycle.
REQ-014 out_data  out  DATA_W  held payload.
REQ-015 out_side  out  SIDE_W  held sideband.
REQ-016 out_bubble  out  1  held word was killed.
REQ-017 stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.

Function
REQ-018 Input fire = in_valid & in_ready; output fire = out_valid & out_ready.
REQ-019 Storage: main register (drives out_*) plus one skid register; state is EMPTY, ONE (main valid) or FULL (main + skid valid).
REQ-020 in_ready = (state != FULL) & ~rst, derived from registered state only; no combinational path from out_ready.
REQ-021 out_valid = (state != EMPTY); out_* come directly from the main register.
REQ-022 EMPTY: input fire -> ONE, main <= input word.
REQ-023 ONE: input fire with output fire -> ONE, main <= input; input fire only -> FULL, skid <= input; output fire only -> EMPTY; neither -> hold.
REQ-024 FULL: output fire -> ONE, main <= skid; no output fire -> hold; no input fire is possible.
REQ-025 Latency: a word accepted in cycle N is presented on out_* in cycle N+1 when the stage was EMPTY, or when it was ONE with an output fire in cycle N.
REQ-026 Throughput: one word per cycle sustained while out_ready=1; order is strictly FIFO, and no word is dropped or duplicated except on flush.
REQ-027 kill with input fire: the stored payload is 0, the sideband is in_side, and the bubble flag is 1; kill without input fire has no effect.
REQ-028 A word stored without kill has its bubble flag set to 0; the bubble flag travels with the word from skid to main.
REQ-029 flush: the next state is EMPTY and main/skid payload, sideband and bubble are cleared to 0; an input offered in the same cycle is discarded; an output fire in the same cycle still counts as consumed downstream.
REQ-030 flush has priority over kill and over every state transition.
REQ-031 stall_cnt increments by 1 in each cycle with out_valid=1 and out_ready=0, and saturates at 2^CNT_W-1 (no wrap); flush does not clear it.

Reset
REQ-032 While rst=1 at posedge clk: state <= EMPTY; out_data, out_side, out_bubble, skid contents <= 0; stall_cnt <= 0.
REQ-033 in_ready=0 and out_valid=0 while rst=1; in_ready=1 in the first cycle after rst deasserts.
REQ-034 rst asserted mid-operation, including in FULL, discards all held words; rst has priority over flush, kill and handshakes.

Verification
REQ-035 Streaming: out_ready=1, in_data=1,2,3 over consecutive cycles -> out_data=1,2,3 one cycle later with out_valid=1 throughout and stall_cnt=0.
REQ-036 Backpressure: out_ready=0 with words A then B offered -> in_ready=0 after B; out stays A and stall_cnt counts; out_ready=1 -> A, then B, with nothing lost.
REQ-037 Kill: in_data=0x8C010004, in_side=0x0000000C_00000008, kill=1 -> out_data=0, out_side=0x0000000C_00000008, out_bubble=1.
REQ-038 Flush in FULL with a simultaneous input offer -> next cycle out_valid=0, in_ready=1, out_data=0; the offered word never appears.
REQ-039 Saturation: CNT_W=4 with out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15 and holds.
REQ-040 Reset mid-stream in FULL -> next cycle all outputs 0, out_valid=0, in_ready=0 while rst is held, then in_ready=1 after release.
